// File: rtl/tmds_channel_encoder_if.sv
// Pixel-side signal bundle for tmds_channel_encoder.
// TMDS_TERC4_EN adds the HDMI data-island signals island/aux.
interface tmds_channel_encoder_if #(
    parameter int NUM_CH = 3,
    parameter int DISP_W = 5
);
    logic                       vde;
    logic [2*NUM_CH-1:0]        ctrl;
    logic [8*NUM_CH-1:0]        data;
    logic [10*NUM_CH-1:0]       tmds;
    logic [DISP_W*NUM_CH-1:0]   disp;
`ifdef TMDS_TERC4_EN
    logic                       island;
    logic [4*NUM_CH-1:0]        aux;

    modport master (output vde, ctrl, data, island, aux, input tmds, disp);
    modport slave  (input vde, ctrl, data, island, aux, output tmds, disp);
`else
    modport master (output vde, ctrl, data, input tmds, disp);
    modport slave  (input vde, ctrl, data, output tmds, disp);
`endif
endinterface

// File: rtl/tmds_channel_encoder.sv
// Multi-lane DVI TMDS encoder: transition-minimising stage, then DC-balancing stage.
// Optional macro TMDS_TERC4_EN adds HDMI TERC4 data-island symbols when vde is low.
module tmds_channel_encoder #(
    parameter int NUM_CH = 3,
    parameter int DISP_W = 5
) (
    input  logic                  pix_clk,
    input  logic                  rst_n,
    tmds_channel_encoder_if.slave bus
);
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic signed [DISP_W-1:0] ZERO  = '0;
    localparam logic signed [DISP_W-1:0] TWO   = DISP_W'(2);
    localparam logic signed [DISP_W-1:0] EIGHT = DISP_W'(8);

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
        logic [9:0] sym;
        case (c)
            2'b00:   sym = CTRL_00;
            2'b01:   sym = CTRL_01;
            2'b10:   sym = CTRL_10;
            default: sym = CTRL_11;
        endcase
        return sym;
    endfunction

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4(input logic [3:0] a);
        logic [9:0] sym;
        case (a)
            4'h0:    sym = 10'b1010011100;
            4'h1:    sym = 10'b1001100011;
            4'h2:    sym = 10'b1011100100;
            4'h3:    sym = 10'b1011100010;
            4'h4:    sym = 10'b0101110001;
            4'h5:    sym = 10'b0100011110;
            4'h6:    sym = 10'b0110001110;
            4'h7:    sym = 10'b0100111100;
            4'h8:    sym = 10'b1011001100;
            4'h9:    sym = 10'b0100111001;
            4'hA:    sym = 10'b0110011100;
            4'hB:    sym = 10'b1011000110;
            4'hC:    sym = 10'b1010001110;
            4'hD:    sym = 10'b1001110001;
            4'hE:    sym = 10'b0101100011;
            default: sym = 10'b1011000011;
        endcase
        return sym;
    endfunction

    logic island_s;
`endif

    logic vde_s;

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            vde_s <= 1'b0;
`ifdef TMDS_TERC4_EN
            island_s <= 1'b0;
`endif
        end else begin
            vde_s <= bus.vde;
`ifdef TMDS_TERC4_EN
            island_s <= bus.island;
`endif
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        logic [7:0]               d;
        logic [3:0]               n1;
        logic                     use_xnor;
        logic [8:0]               qm;
        logic [8:0]               qm_s;
        logic [3:0]               ones_s;
        logic [1:0]               ctrl_s;
        logic signed [DISP_W-1:0] n1_s;
        logic signed [DISP_W-1:0] diff;
        logic signed [DISP_W-1:0] cnt_r;
        logic signed [DISP_W-1:0] cnt_nxt;
        logic [9:0]               tmds_r;
        logic [9:0]               tmds_nxt;
`ifdef TMDS_TERC4_EN
        logic [3:0]               aux_s;
`endif

        assign d = bus.data[8*k +: 8];

        always_comb begin
            n1       = 4'($countones(d));
            use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
            qm       = '0;
            qm[0]    = d[0];
            for (int i = 1; i < 8; i++) begin
                qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
            end
            qm[8] = ~use_xnor;
        end

        always_ff @(posedge pix_clk or negedge rst_n) begin
            if (!rst_n) begin
                qm_s   <= '0;
                ones_s <= '0;
                ctrl_s <= 2'b00;
`ifdef TMDS_TERC4_EN
                aux_s  <= '0;
`endif
            end else begin
                qm_s   <= qm;
                ones_s <= 4'($countones(qm[7:0]));
                ctrl_s <= bus.ctrl[2*k +: 2];
`ifdef TMDS_TERC4_EN
                aux_s  <= bus.aux[4*k +: 4];
`endif
            end
        end

        // diff = N1 - N0; a nonzero cnt with the same sign as diff means the symbol must be inverted
        always_comb begin
            n1_s     = DISP_W'(ones_s);
            diff     = n1_s + n1_s - EIGHT;
            tmds_nxt = CTRL_00;
            cnt_nxt  = cnt_r;
            if (!vde_s) begin
                cnt_nxt  = ZERO;
                tmds_nxt = ctrl_symbol(ctrl_s);
`ifdef TMDS_TERC4_EN
                if (island_s) begin
                    tmds_nxt = terc4(aux_s);
                end
`endif
            end else if ((cnt_r == ZERO) || (diff == ZERO)) begin
                tmds_nxt = {~qm_s[8], qm_s[8], qm_s[8] ? qm_s[7:0] : ~qm_s[7:0]};
                cnt_nxt  = qm_s[8] ? (cnt_r + diff) : (cnt_r - diff);
            end else if (cnt_r[DISP_W-1] == diff[DISP_W-1]) begin
                tmds_nxt = {1'b1, qm_s[8], ~qm_s[7:0]};
                cnt_nxt  = cnt_r - diff + (qm_s[8] ? TWO : ZERO);
            end else begin
                tmds_nxt = {1'b0, qm_s[8], qm_s[7:0]};
                cnt_nxt  = cnt_r + diff - (qm_s[8] ? ZERO : TWO);
            end
        end

        always_ff @(posedge pix_clk or negedge rst_n) begin
            if (!rst_n) begin
                tmds_r <= CTRL_00;
                cnt_r  <= ZERO;
            end else begin
                tmds_r <= tmds_nxt;
                cnt_r  <= cnt_nxt;
            end
        end

        assign bus.tmds[10*k +: 10]        = tmds_r;
        assign bus.disp[DISP_W*k +: DISP_W] = cnt_r;
    end
endmodule

// File: doc/tmds_channel_encoder.md
# tmds_channel_encoder

Parametrised multi-channel TMDS encoder for the DVI/HDMI output path. Takes per-channel 8-bit pixel data, 2-bit control and a shared video-data-enable. Produces DVI 1.0 DC-balanced 10-bit symbols with a registered two-stage pipeline and a per-channel running-disparity counter. Sits between the pixel timing generator (x/y counters, `pix_clk` domain) and the 10:1 serialisers on `tmds_clk`.

## Interface
- `NUM_CH`, default 3: number of independent TMDS channels (B, G, R in lanes 0, 1, 2).
- `DISP_W`, default 5: width of the signed running-disparity counter, two's complement; must be ≥ 5.
- `pix_clk` in 1: pixel clock; all state on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `vde` in 1: video data enable, shared by all channels.
- `ctrl` in 2*NUM_CH: control bits {C1,C0} per channel; lane k = `ctrl[2k+1:2k]`.
- `data` in 8*NUM_CH: pixel byte per channel; lane k = `data[8k+7:8k]`.
- `tmds` out 10*NUM_CH: encoded symbol per channel; lane k = `tmds[10k+9:10k]`; bit 0 is transmitted first.
- `disp` out DISP_W*NUM_CH: running disparity per channel after the symbol currently on `tmds`.

## Operation
- Lanes are identical and independent; there is no cross-lane state.
- Stage 1 (transition minimisation) registers, per lane:
  - q_m[8:0]: n1 = popcount(data); use XNOR when n1>4, or n1==4 and data[0]==0, else XOR.
  - q_m[0]=d[0]; q_m[i] = q_m[i-1] XOR/XNOR d[i].
  - q_m[8] = 1 for XOR, 0 for XNOR.
  - Also registers ones(q_m[7:0]), `vde` and `ctrl`.
- Stage 2 (DC balance), using staged values: N1 = ones(q_m[7:0]), N0 = 8−N1, cnt = current disparity.
  - cnt==0 or N1==N0: out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m8 ? (N1−N0) : (N0−N1).
  - (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out = {1, q_m8, ~q_m[7:0]}.
    - cnt += 2·q_m8 + (N0−N1).
  - Otherwise: out = {0, q_m8, q_m[7:0]}.
    - cnt += −2·(~q_m8) + (N1−N0).
- Staged vde==0: out = control symbol; cnt ← 0.
  - C1C0 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
- Arithmetic is signed DISP_W-bit. The DVI algorithm bounds |cnt| ≤ 10, so no overflow occurs and no saturation logic is present.

## Timing
- Latency: exactly 2 `pix_clk` cycles from `data`/`ctrl`/`vde` sampled at edge n to `tmds`/`disp` valid after edge n+2.
- Throughput: one symbol per lane per cycle; no stalls and no handshake.
- `disp` updates on the same edge as `tmds`.
- vde 1→0 transition: the first control symbol appears 2 cycles later, and `disp` reads 0 on that same cycle.
- vde 0→1 transition: the first data symbol is encoded from cnt = 0.
- Reset (asynchronous, any time including mid-line):
  - all pipeline registers clear: staged vde=0, ctrl=00;
  - every `tmds` lane = 1101010100; every `disp` lane = 0.
- Reset release: first real output appears 2 edges after the first sampled input.

## Configuration
- Macro `TMDS_TERC4_EN` adds the HDMI data-island mode.
- Defined:
  - Extra ports `island` in 1 and `aux` in 4*NUM_CH, pipelined alongside `vde`.
  - When staged vde==0 and island==1, the lane outputs the HDMI 1.4 TERC4 symbol of its aux nibble (e.g. 0000 → 1010011100, 0001 → 1001100011, 1111 → 1011000011) and cnt ← 0.
  - `vde`=1 overrides `island`.
- Undefined: `island` and `aux` ports do not exist; vde==0 always produces control symbols.

## Test plan
- Reset: hold rst_n=0, toggle inputs → every `tmds` lane = 1101010100 and every `disp` = 0; assert rst_n mid-stream → outputs change asynchronously, before the next edge.
- Control: vde=0, lane-0 ctrl=11, lane-1 ctrl=01 → two cycles later lane 0 = 1010101011, lane 1 = 0010101011, disp=0.
- Balance, XOR path: vde=1, data=0x00 for three cycles from cnt=0 → tmds 0100000000, 1111111111, 0100000000; disp −8, +2, −6.
- Balance, XNOR path: vde=1, single 0xFF from cnt=0 → tmds 1000000000, disp −8; then vde=0 → control symbol and disp=0 exactly 2 cycles after the vde drop.
- Lane independence and reference check (NUM_CH=3): random data/ctrl/vde for 10k cycles, each lane compared against a bit-exact software model; disp never exceeds ±10.
- With `TMDS_TERC4_EN`: vde=0, island=1, aux lane 0 = 0001 → lane 0 = 1001100011 after 2 cycles; raising vde=1 in the same cycle → data symbol instead.
